// File: rtl/ooo_regfile_pkg.sv
// Shared constants and writeback-side port type for the out-of-order core register file.
// Parameter-dependent word/address types stay local to the modules that use them.
package ooo_regfile_pkg;

    localparam int RF_WIDTH   = 32;
    localparam int RF_DEPTH   = 32;
    localparam int RF_N_WRITE = 2;
    localparam int RF_N_READ  = 4;

    localparam int RF_ADDR_WIDTH = $clog2(RF_DEPTH);

    // One writeback port as seen by the writeback network.
    typedef struct packed {
        logic                     wen;
        logic [RF_ADDR_WIDTH-1:0] waddr;
        logic [RF_WIDTH-1:0]      wdata;
    } wr_port_t;

endpackage

// File: rtl/regfile_write_resolve.sv
// Resolves all write ports against one query address: reports whether any effective
// write hits it and, if several do, the data of the highest-index port.
module regfile_write_resolve
    import ooo_regfile_pkg::*;
#(
    parameter int WIDTH      = RF_WIDTH,
    parameter int ADDR_WIDTH = $clog2(RF_DEPTH),
    parameter int N_WRITE    = RF_N_WRITE,
    parameter int ZERO_REG   = 1
) (
    input  logic [N_WRITE-1:0]                 wen,
    input  logic [N_WRITE-1:0][ADDR_WIDTH-1:0] waddr,
    input  logic [N_WRITE-1:0][WIDTH-1:0]      wdata,
    input  logic [ADDR_WIDTH-1:0]              qaddr,
    output logic                               hit,
    output logic [WIDTH-1:0]                   data
);

    // NOTE: defaults assigned first so every path through the loop drives both
    // outputs; without them this block would infer latches.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        // Ascending scan: a later (higher-index) match overwrites an earlier one.
        for (int i = 0; i < N_WRITE; i++) begin
            if (wen[i] && !(ZERO_REG != 0 && waddr[i] == '0) && waddr[i] == qaddr) begin
                hit  = 1'b1;
                data = wdata[i];
            end
        end
    end

endmodule

// File: rtl/bypass_regfile.sv
// Multi-port register file with write-through bypass, registered read ports, per-port
// hold-and-refresh, highest-port-wins write priority and an optional hardwired zero entry.
module bypass_regfile
    import ooo_regfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int DEPTH    = RF_DEPTH,
    parameter int N_WRITE  = RF_N_WRITE,
    parameter int N_READ   = RF_N_READ,
    parameter int ZERO_REG = 1
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [N_WRITE-1:0]                        wen,
    input  logic [N_WRITE-1:0][$clog2(DEPTH)-1:0]     waddr,
    input  logic [N_WRITE-1:0][WIDTH-1:0]             wdata,
    input  logic [N_READ-1:0]                         ren,
    input  logic [N_READ-1:0][$clog2(DEPTH)-1:0]      raddr,
    output logic [N_READ-1:0][WIDTH-1:0]              rdata
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);

    typedef logic [WIDTH-1:0]      word_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    word_t mem [DEPTH];
    addr_t haddr [N_READ];

    logic  [DEPTH-1:0]  ent_hit;
    word_t              ent_data [DEPTH];

    addr_t              rd_qaddr [N_READ];
    logic  [N_READ-1:0] rd_zero;
    logic  [N_READ-1:0] rd_hit;
    word_t              rd_data [N_READ];

    // Per-entry write resolution drives the array update.
    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        regfile_write_resolve #(
            .WIDTH      (WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .N_WRITE    (N_WRITE),
            .ZERO_REG   (ZERO_REG)
        ) u_resolve (
            .wen   (wen),
            .waddr (waddr),
            .wdata (wdata),
            .qaddr (addr_t'(e)),
            .hit   (ent_hit[e]),
            .data  (ent_data[e])
        );
    end

    // A port looks at the new address when enabled, otherwise at the address it holds.
    always_comb begin
        for (int j = 0; j < N_READ; j++) begin
            rd_qaddr[j] = ren[j] ? raddr[j] : haddr[j];
            rd_zero[j]  = (ZERO_REG != 0) && (rd_qaddr[j] == '0);
        end
    end

    for (genvar j = 0; j < N_READ; j++) begin : g_read
        regfile_write_resolve #(
            .WIDTH      (WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .N_WRITE    (N_WRITE),
            .ZERO_REG   (ZERO_REG)
        ) u_bypass (
            .wen   (wen),
            .waddr (waddr),
            .wdata (wdata),
            .qaddr (rd_qaddr[j]),
            .hit   (rd_hit[j]),
            .data  (rd_data[j])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so every read below sees
    // the pre-edge array contents, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the array is deliberately cleared on reset, which forces flops
            // rather than a RAM macro; readers rely on all-zero contents after reset.
            for (int e = 0; e < DEPTH; e++) begin
                mem[e] <= '0;
            end
            for (int j = 0; j < N_READ; j++) begin
                haddr[j] <= '0;
                rdata[j] <= '0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (ent_hit[e]) begin
                    mem[e] <= ent_data[e];
                end
            end
            for (int j = 0; j < N_READ; j++) begin
                if (ren[j]) begin
                    haddr[j] <= raddr[j];
                    if (rd_zero[j]) begin
                        rdata[j] <= '0;
                    end else if (rd_hit[j]) begin
                        rdata[j] <= rd_data[j];
                    end else begin
                        rdata[j] <= mem[raddr[j]];
                    end
                end else if (rd_hit[j]) begin
                    // Held port refreshes when its address is written.
                    rdata[j] <= rd_zero[j] ? '0 : rd_data[j];
                end
            end
        end
    end

endmodule

// File: tb/tb_bypass_regfile.sv
// Self-checking bench for bypass_regfile: directed scenarios plus randomized traffic,
// run on a ZERO_REG=1 and a ZERO_REG=0 instance against a behavioural reference model.
module tb_bypass_regfile;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int NW = 2;
    localparam int NR = 4;
    localparam int AW = $clog2(D);

    logic                    clk;
    logic                    reset;
    logic [NW-1:0]           wen;
    logic [NW-1:0][AW-1:0]   waddr;
    logic [NW-1:0][W-1:0]    wdata;
    logic [NR-1:0]           ren;
    logic [NR-1:0][AW-1:0]   raddr;
    logic [NR-1:0][W-1:0]    rdata_z;
    logic [NR-1:0][W-1:0]    rdata_n;

    int checks = 0;
    int errors = 0;

    // Reference model, index 0: ZERO_REG=1, index 1: ZERO_REG=0.
    logic [W-1:0]  m_mem  [2][D];
    logic [AW-1:0] m_hold [2][NR];
    logic [W-1:0]  m_exp  [2][NR];

    bypass_regfile #(.WIDTH(W), .DEPTH(D), .N_WRITE(NW), .N_READ(NR), .ZERO_REG(1)) dut (
        .clk   (clk),
        .reset (reset),
        .wen   (wen),
        .waddr (waddr),
        .wdata (wdata),
        .ren   (ren),
        .raddr (raddr),
        .rdata (rdata_z)
    );

    bypass_regfile #(.WIDTH(W), .DEPTH(D), .N_WRITE(NW), .N_READ(NR), .ZERO_REG(0)) dut_nz (
        .clk   (clk),
        .reset (reset),
        .wen   (wen),
        .waddr (waddr),
        .wdata (wdata),
        .ren   (ren),
        .raddr (raddr),
        .rdata (rdata_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model: apply the cycle's writes in port order to a copy of the array (later ports
    // overwrite earlier ones), then every read sees the post-write contents.
    task automatic model_step();
        for (int z = 0; z < 2; z++) begin
            logic [W-1:0] nm [D];
            bit           written [D];
            if (reset) begin
                for (int a = 0; a < D; a++) m_mem[z][a] = '0;
                for (int j = 0; j < NR; j++) begin
                    m_hold[z][j] = '0;
                    m_exp[z][j]  = '0;
                end
            end else begin
                for (int a = 0; a < D; a++) begin
                    nm[a]      = m_mem[z][a];
                    written[a] = 1'b0;
                end
                for (int i = 0; i < NW; i++) begin
                    if (wen[i] && !(z == 0 && waddr[i] == 0)) begin
                        nm[waddr[i]]      = wdata[i];
                        written[waddr[i]] = 1'b1;
                    end
                end
                for (int j = 0; j < NR; j++) begin
                    if (ren[j]) begin
                        m_hold[z][j] = raddr[j];
                        m_exp[z][j]  = nm[raddr[j]];
                    end else if (written[m_hold[z][j]]) begin
                        m_exp[z][j] = nm[m_hold[z][j]];
                    end
                end
                for (int a = 0; a < D; a++) m_mem[z][a] = nm[a];
            end
        end
    endtask

    // One clock: update the model at the edge, sample outputs 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        for (int j = 0; j < NR; j++) begin
            check($sformatf("model_z port%0d", j), rdata_z[j], m_exp[0][j]);
            check($sformatf("model_nz port%0d", j), rdata_n[j], m_exp[1][j]);
        end
    endtask

    task automatic idle();
        wen   = '0;
        waddr = '0;
        wdata = '0;
        ren   = '0;
        raddr = '0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #2;

        // Reset ignores writes; read after reset returns 0.
        wen   = 2'b11;
        waddr = {5'd5, 5'd5};
        wdata = {32'hDEAD, 32'hDEAD};
        ren   = 4'b1111;
        raddr = {5'd5, 5'd5, 5'd5, 5'd5};
        tick();
        tick();
        reset = 1'b0;
        idle();
        ren      = 4'b0001;
        raddr[0] = 5'd5;
        tick();
        check("reset_read_z", rdata_z[0], 32'h0);
        check("reset_read_nz", rdata_n[0], 32'h0);

        // Write-through bypass, then plain read.
        idle();
        wen[0]   = 1'b1;
        waddr[0] = 5'd7;
        wdata[0] = 32'h1234;
        ren[1]   = 1'b1;
        raddr[1] = 5'd7;
        tick();
        check("bypass_same_cycle", rdata_z[1], 32'h1234);
        wen = '0;
        tick();
        check("bypass_next_read", rdata_z[1], 32'h1234);

        // Highest port wins a same-address collision.
        idle();
        wen      = 2'b11;
        waddr    = {5'd3, 5'd3};
        wdata    = {32'hBBBB, 32'hAAAA};
        ren[0]   = 1'b1;
        raddr[0] = 5'd3;
        tick();
        check("prio_bypass", rdata_z[0], 32'hBBBB);
        wen = '0;
        tick();
        check("prio_array", rdata_n[0], 32'hBBBB);

        // Hold with refresh on a write to the held address only.
        idle();
        wen[0]   = 1'b1;
        waddr[0] = 5'd9;
        wdata[0] = 32'h10;
        tick();
        idle();
        ren[2]   = 1'b1;
        raddr[2] = 5'd9;
        tick();
        check("hold_initial", rdata_z[2], 32'h10);
        idle();
        wen[0]   = 1'b1;
        waddr[0] = 5'd9;
        wdata[0] = 32'h20;
        tick();
        check("hold_refresh", rdata_z[2], 32'h20);
        waddr[0] = 5'd8;
        wdata[0] = 32'h30;
        tick();
        check("hold_other_addr", rdata_z[2], 32'h20);

        // Zero entry: hardwired in one instance, ordinary in the other.
        idle();
        wen[1]   = 1'b1;
        waddr[1] = 5'd0;
        wdata[1] = 32'hFFFF;
        ren[3]   = 1'b1;
        raddr[3] = 5'd0;
        tick();
        check("zero_bypass_z", rdata_z[3], 32'h0);
        check("zero_bypass_nz", rdata_n[3], 32'hFFFF);
        wen = '0;
        tick();
        check("zero_read_z", rdata_z[3], 32'h0);
        check("zero_read_nz", rdata_n[3], 32'hFFFF);

        // Mid-operation reset clears array, held addresses and outputs.
        idle();
        wen[0]   = 1'b1;
        waddr[0] = 5'd4;
        wdata[0] = 32'h55;
        ren[2]   = 1'b1;
        raddr[2] = 5'd4;
        tick();
        check("midreset_pre", rdata_z[2], 32'h55);
        idle();
        reset = 1'b1;
        wen   = 2'b11;
        waddr = {5'd4, 5'd4};
        wdata = {32'h77, 32'h77};
        tick();
        for (int j = 0; j < NR; j++) begin
            check($sformatf("midreset_out_z%0d", j), rdata_z[j], 32'h0);
            check($sformatf("midreset_out_nz%0d", j), rdata_n[j], 32'h0);
        end
        reset = 1'b0;
        idle();
        ren[2]   = 1'b1;
        raddr[2] = 5'd4;
        tick();
        check("midreset_read", rdata_z[2], 32'h0);
        check("midreset_read_nz", rdata_n[2], 32'h0);

        // Randomized traffic on a narrow address window to force collisions and hold hits.
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 49) == 0);
            wen   = NW'($urandom);
            ren   = NR'($urandom);
            for (int i = 0; i < NW; i++) begin
                waddr[i] = AW'($urandom_range(0, 7));
                wdata[i] = $urandom;
            end
            for (int j = 0; j < NR; j++) begin
                raddr[j] = AW'($urandom_range(0, 7));
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
